// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a tenure limit on contended grants.
// Every output is registered; gnt_idx keeps the last owner while idle.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             valid_q, valid_d;

   logic [3:0]       others_s;
   logic [2:0]       pick_all_s;
   logic [2:0]       pick_oth_s;
   logic             take_s;
   logic [1:0]       win_s;

   // Returns {found, index} of the first set bit of mask, scanning from start with wrap.
   function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] j;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         j = start + 2'(i);
         if (mask[j]) begin
            res = {1'b1, j};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign others_s   = req & ~(4'b0001 << idx_q);
   assign pick_all_s = pick(req, ptr_q);
   assign pick_oth_s = pick(others_s, ptr_q);

   // Next-state decision: new grant, hold with tenure count, or fall back to idle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      take_s  = 1'b0;
      win_s   = 2'b00;

      case (state_q)
         IDLE: begin
            if (|req) begin
               take_s = 1'b1;
               win_s  = pick_all_s[1:0];
            end else begin
               take_s = 1'b0;
            end
         end
         GRANT: begin
            if (!req[idx_q]) begin
               if (pick_oth_s[2]) begin
                  take_s = 1'b1;
                  win_s  = pick_oth_s[1:0];
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  gnt_d   = 4'b0000;
               end
            end else if ((cnt_q >= CNT_MAX) && pick_oth_s[2]) begin
               // Tenure expired under contention: ptr already sits past the owner.
               take_s = 1'b1;
               win_s  = pick_oth_s[1:0];
            end else if (cnt_q >= CNT_MAX) begin
               cnt_d = CNT_MAX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = 4'b0000;
         end
      endcase

      if (take_s) begin
         state_d = GRANT;
         idx_d   = win_s;
         gnt_d   = 4'b0001 << win_s;
         valid_d = 1'b1;
         ptr_d   = win_s + 2'd1;
         cnt_d   = '0;
      end else begin
         idx_d = idx_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'b00;
         cnt_q   <= '0;
         gnt_q   <= 4'b0000;
         idx_q   <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

endmodule
